// File: rtl/ranc_ingress_pkg.sv
// Shared definitions for the RANC AXIS ingress: field positions, width helpers
// and the AXIS-side FSM state encoding.
package ranc_ingress_pkg;

  // Packet bits always start at tdata[0]; the channel field sits directly above.
  localparam int PKT_LSB = 0;

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_DROP  = 2'd1,
    ST_FLUSH = 2'd2
  } ingress_state_e;

  // Channel field width; at least one bit even for a single channel.
  function automatic int ch_width(input int num_channels);
    return (num_channels <= 2) ? 1 : $clog2(num_channels);
  endfunction

  // Pointer width including the wrap bit used to tell full from empty.
  function automatic int ptr_width(input int fifo_depth);
    return $clog2(fifo_depth) + 1;
  endfunction

  // Channel field LSB within tdata.
  function automatic int ch_field_lsb(input int packet_width);
    return packet_width;
  endfunction

endpackage

// File: rtl/ranc_ingress_channel_fifo.sv
// One injection channel: a FWFT FIFO with four pointers.
//   rd..rel   released packets visible to the grid
//   rel..cmt  committed packets waiting for the next tick
//   cmt..wr   words of the frame currently being received
module ranc_ingress_channel_fifo
  import ranc_ingress_pkg::*;
#(
  parameter int PACKET_WIDTH = 30,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               wr_en,
  input  logic [PACKET_WIDTH-1:0]            wr_data,
  input  logic                               commit,
  input  logic                               rollback,
  input  logic                               rel_en,
  input  logic                               ren,
  input  logic                               clear,
  output logic [PACKET_WIDTH-1:0]            dout,
  output logic                               empty,
  output logic                               full,
  output logic                               read_err,
  output logic [ptr_width(FIFO_DEPTH)-1:0]   fill
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_q, wr_d;
  logic [PTR_W-1:0]        cmt_q, cmt_d;
  logic [PTR_W-1:0]        rel_q, rel_d;
  logic [PTR_W-1:0]        rd_q, rd_d;
  logic                    push;

  assign fill     = wr_q - rd_q;
  assign full     = (fill == PTR_W'(FIFO_DEPTH));
  assign empty    = (rd_q == rel_q);
  assign dout     = mem_q[rd_q[AW-1:0]];
  assign read_err = ren & empty;
  assign push     = wr_en & ~full & ~clear;

  // Pointer next-state: commit sees this cycle's write, release sees this cycle's commit.
  always_comb begin
    wr_d  = wr_q;
    cmt_d = cmt_q;
    rel_d = rel_q;
    rd_d  = rd_q;
    if (push)     wr_d = wr_q + PTR_W'(1);
    if (rollback) wr_d = cmt_q;
    if (commit)   cmt_d = wr_d;
    if (rel_en)   rel_d = cmt_d;
    if (ren && !empty) rd_d = rd_q + PTR_W'(1);
    if (clear) begin
      wr_d  = '0;
      cmt_d = '0;
      rel_d = '0;
      rd_d  = '0;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q  <= '0;
      cmt_q <= '0;
      rel_q <= '0;
      rd_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      cmt_q <= cmt_d;
      rel_q <= rel_d;
      rd_q  <= rd_d;
    end
  end

  // Packet storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ranc_axis_ingress.sv
// Multi-channel tick-framed AXIS ingress for the RANC grid.
// Steers each AXIS word to a per-channel FIFO, commits on TLAST, releases
// committed frames on tick, drops whole frames on overflow or bad channel.
// Optional build macro RANC_INGRESS_STATS_EN adds saturating counters
// stat_accepted / stat_dropped / stat_released.
module ranc_axis_ingress
  import ranc_ingress_pkg::*;
#(
  parameter int PACKET_WIDTH = 30,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 512,
  parameter int TDATA_WIDTH  = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                 s_axis_tlast,
  input  logic                                 tick,
  input  logic                                 flush,
  output logic [NUM_CHANNELS*PACKET_WIDTH-1:0] ch_dout,
  output logic [NUM_CHANNELS-1:0]              ch_empty,
  input  logic [NUM_CHANNELS-1:0]              ch_ren,
  output logic                                 frame_drop,
  output logic                                 overflow_error,
  output logic                                 read_error
`ifdef RANC_INGRESS_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                 stat_accepted,
  output logic [CNT_WIDTH-1:0]                 stat_dropped,
  output logic [CNT_WIDTH-1:0]                 stat_released
`endif
);

  localparam int CH_W    = ch_width(NUM_CHANNELS);
  localparam int PTR_W   = ptr_width(FIFO_DEPTH);
  localparam int CH_LSB  = ch_field_lsb(PACKET_WIDTH);
  localparam int NCH_PAD = 1 << CH_W;

  ingress_state_e state_q, state_d;
  logic tready_q, tready_d;
  logic drop_q, drop_d;
  logic ovf_q, ovf_d;
  logic rderr_q, rderr_d;

  logic                              beat;
  logic [CH_W-1:0]                   ch_sel;
  logic [PACKET_WIDTH-1:0]           pkt;
  logic                              ch_ok;
  logic [NCH_PAD-1:0]                full_pad;
  logic [NUM_CHANNELS-1:0]           ch_full;
  logic [NUM_CHANNELS-1:0]           ch_rderr;
  logic [NUM_CHANNELS-1:0][PTR_W-1:0] ch_fill;
  logic do_write, do_commit, do_rollback, do_clear;
  logic unused_bits;

  assign beat   = s_axis_tvalid & tready_q;
  assign ch_sel = s_axis_tdata[CH_LSB +: CH_W];
  assign pkt    = s_axis_tdata[PKT_LSB +: PACKET_WIDTH];

  assign s_axis_tready  = tready_q;
  assign frame_drop     = drop_q;
  assign overflow_error = ovf_q;
  assign read_error     = rderr_q;
  assign unused_bits    = ^{s_axis_tdata, ch_fill};

  // Pad the full flags so an out-of-range channel code still indexes safely.
  always_comb begin
    full_pad = '0;
    full_pad[NUM_CHANNELS-1:0] = ch_full;
    ch_ok = (int'(ch_sel) < NUM_CHANNELS) && !full_pad[ch_sel];
  end

  // AXIS FSM: flush wins over everything; a rejected beat rolls the frame back.
  always_comb begin
    state_d     = state_q;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    do_clear    = 1'b0;
    drop_d      = 1'b0;
    ovf_d       = ovf_q;
    rderr_d     = rderr_q | (|ch_rderr);
    if (flush) begin
      state_d  = ST_FLUSH;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (beat) begin
            if (ch_ok) begin
              do_write  = 1'b1;
              do_commit = s_axis_tlast;
            end else begin
              do_rollback = 1'b1;
              drop_d      = 1'b1;
              ovf_d       = 1'b1;
              if (!s_axis_tlast) state_d = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (beat && s_axis_tlast) state_d = ST_RECV;
        end
        ST_FLUSH: state_d = ST_RECV;
        default:  state_d = ST_RECV;
      endcase
    end
    tready_d = (state_d != ST_FLUSH);
  end

  // Control registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_RECV;
      tready_q <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tready_q <= tready_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      rderr_q  <= rderr_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    ranc_ingress_channel_fifo #(
      .PACKET_WIDTH (PACKET_WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .aresetn  (aresetn),
      .wr_en    (do_write && (ch_sel == CH_W'(g))),
      .wr_data  (pkt),
      .commit   (do_commit),
      .rollback (do_rollback),
      .rel_en   (tick),
      .ren      (ch_ren[g]),
      .clear    (do_clear),
      .dout     (ch_dout[g*PACKET_WIDTH +: PACKET_WIDTH]),
      .empty    (ch_empty[g]),
      .full     (ch_full[g]),
      .read_err (ch_rderr[g]),
      .fill     (ch_fill[g])
    );
  end

`ifdef RANC_INGRESS_STATS_EN
  logic [31:0]          frm_cnt_q, frm_cnt_d;
  logic [31:0]          fill_sum, acc_inc, drp_inc, rel_inc;
  logic [CNT_WIDTH-1:0] acc_q, acc_d, drp_q, drp_d, rls_q, rls_d;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                  input logic [31:0] inc);
    logic [32:0] s;
    s = 33'(a) + 33'(inc);
    if (s > 33'({CNT_WIDTH{1'b1}})) return {CNT_WIDTH{1'b1}};
    return s[CNT_WIDTH-1:0];
  endfunction

  // Word accounting: frm_cnt tracks words of the frame written but not yet committed.
  always_comb begin
    fill_sum = '0;
    rel_inc  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      fill_sum = fill_sum + 32'(ch_fill[c]);
      rel_inc  = rel_inc + 32'(ch_ren[c] & ~ch_empty[c]);
    end
    frm_cnt_d = frm_cnt_q;
    acc_inc   = '0;
    drp_inc   = '0;
    if (do_clear) begin
      frm_cnt_d = '0;
      drp_inc   = fill_sum + 32'(beat);
    end else if (do_rollback) begin
      frm_cnt_d = '0;
      drp_inc   = frm_cnt_q + 32'd1;
    end else if (do_commit) begin
      frm_cnt_d = '0;
      acc_inc   = frm_cnt_q + 32'd1;
    end else if (do_write) begin
      frm_cnt_d = frm_cnt_q + 32'd1;
    end else if (state_q == ST_DROP && beat) begin
      drp_inc = 32'd1;
    end
    acc_d = sat_add(acc_q, acc_inc);
    drp_d = sat_add(drp_q, drp_inc);
    rls_d = sat_add(rls_q, rel_inc);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      frm_cnt_q <= '0;
      acc_q     <= '0;
      drp_q     <= '0;
      rls_q     <= '0;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      acc_q     <= acc_d;
      drp_q     <= drp_d;
      rls_q     <= rls_d;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drp_q;
  assign stat_released = rls_q;
`endif

endmodule

// File: tb/tb_ranc_axis_ingress.sv
// Testbench for ranc_axis_ingress (3 channels, depth 4): directed scenarios
// with literal expectations plus a randomized run, all outputs compared every
// cycle against a queue-based frame model.
module tb_ranc_axis_ingress;

  localparam int PW    = 30;
  localparam int NCH   = 3;
  localparam int DEPTH = 4;
  localparam int TDW   = 32;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic aresetn = 1'b1;
  logic tvalid = 1'b0;
  logic tready;
  logic [TDW-1:0] tdata = '0;
  logic tlast = 1'b0, tick = 1'b0, flush = 1'b0;
  logic [NCH*PW-1:0] ch_dout;
  logic [NCH-1:0] ch_empty;
  logic [NCH-1:0] ch_ren = '0;
  logic frame_drop, overflow_error, read_error;
`ifdef RANC_INGRESS_STATS_EN
  logic [CW-1:0] stat_accepted, stat_dropped, stat_released;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ranc_axis_ingress #(
    .PACKET_WIDTH (PW),
    .NUM_CHANNELS (NCH),
    .FIFO_DEPTH   (DEPTH),
    .TDATA_WIDTH  (TDW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .s_axis_tvalid  (tvalid),
    .s_axis_tready  (tready),
    .s_axis_tdata   (tdata),
    .s_axis_tlast   (tlast),
    .tick           (tick),
    .flush          (flush),
    .ch_dout        (ch_dout),
    .ch_empty       (ch_empty),
    .ch_ren         (ch_ren),
    .frame_drop     (frame_drop),
    .overflow_error (overflow_error),
    .read_error     (read_error)
`ifdef RANC_INGRESS_STATS_EN
    ,
    .stat_accepted  (stat_accepted),
    .stat_dropped   (stat_dropped),
    .stat_released  (stat_released)
`endif
  );

  // ---------------- reference model ----------------
  // st[c] holds every stored word of channel c in order: the first n_rel are
  // released, the next n_com committed, the rest belong to the open frame.
  logic [PW-1:0] st [NCH][$];
  int  n_rel [NCH];
  int  n_com [NCH];
  bit  m_drop, m_tready, m_fd, m_ovf, m_rderr;
  int  m_acc, m_dropped, m_rel;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit beat, ok;
    int ch, total, pend;
    beat  = tvalid && m_tready;
    ch    = int'(tdata[PW +: 2]);
    ok    = (ch < NCH) ? (st[ch].size() < DEPTH) : 1'b0;
    total = 0;
    for (int c = 0; c < NCH; c++) total += st[c].size();
    m_fd = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_ren[c]) begin
        if (n_rel[c] > 0) begin
          void'(st[c].pop_front());
          n_rel[c]--;
          m_rel++;
        end else begin
          m_rderr = 1'b1;
        end
      end
    end
    if (flush) begin
      m_dropped += total + (beat ? 1 : 0);
      for (int c = 0; c < NCH; c++) begin
        st[c].delete();
        n_rel[c] = 0;
        n_com[c] = 0;
      end
      m_drop   = 1'b0;
      m_tready = 1'b0;
    end else begin
      if (beat) begin
        if (m_drop) begin
          m_dropped++;
          if (tlast) m_drop = 1'b0;
        end else if (ok) begin
          st[ch].push_back(tdata[PW-1:0]);
          if (tlast) begin
            pend = 0;
            for (int c = 0; c < NCH; c++) begin
              pend += st[c].size() - n_rel[c] - n_com[c];
              n_com[c] = st[c].size() - n_rel[c];
            end
            m_acc += pend;
          end
        end else begin
          pend = 0;
          for (int c = 0; c < NCH; c++) begin
            while (st[c].size() > n_rel[c] + n_com[c]) begin
              void'(st[c].pop_back());
              pend++;
            end
          end
          m_dropped += pend + 1;
          m_fd  = 1'b1;
          m_ovf = 1'b1;
          if (!tlast) m_drop = 1'b1;
        end
      end
      if (tick) begin
        for (int c = 0; c < NCH; c++) begin
          n_rel[c] += n_com[c];
          n_com[c] = 0;
        end
      end
      m_tready = 1'b1;
    end
  endtask

  // Model state advances with the DUT clock and resets asynchronously with it.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        st[c].delete();
        n_rel[c] = 0;
        n_com[c] = 0;
      end
      m_drop = 0; m_tready = 0; m_fd = 0; m_ovf = 0; m_rderr = 0;
      m_acc = 0; m_dropped = 0; m_rel = 0;
    end else begin
      model_step();
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NCH-1:0] ev;
      for (int c = 0; c < NCH; c++) ev[c] = (n_rel[c] == 0);
      check("tready", tready, m_tready);
      check("ch_empty", ch_empty, ev);
      for (int c = 0; c < NCH; c++)
        if (n_rel[c] > 0) check("ch_dout", ch_dout[c*PW +: PW], st[c][0]);
      check("frame_drop", frame_drop, m_fd);
      check("overflow_error", overflow_error, m_ovf);
      check("read_error", read_error, m_rderr);
`ifdef RANC_INGRESS_STATS_EN
      check("stat_accepted", stat_accepted, (m_acc > 65535) ? 65535 : m_acc);
      check("stat_dropped", stat_dropped, (m_dropped > 65535) ? 65535 : m_dropped);
      check("stat_released", stat_released, (m_rel > 65535) ? 65535 : m_rel);
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [TDW-1:0] w(input int ch, input logic [PW-1:0] p);
    return {2'(ch), p};
  endfunction

  task automatic step(input bit v, input logic [TDW-1:0] d, input bit l,
                      input bit tk, input bit fl, input logic [NCH-1:0] r);
    tvalid = v; tdata = d; tlast = l; tick = tk; flush = fl; ch_ren = r;
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0; tick = 1'b0; flush = 1'b0; ch_ren = '0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] r;
    int ch;
    #2 aresetn = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_tready", tready, 0);
    check("rst_empty", ch_empty, 3'b111);
    check("rst_ovf", overflow_error, 0);
    check("rst_rderr", read_error, 0);
    #20 aresetn = 1'b1;
    @(posedge clk); #1;
    check("tready_up", tready, 1);

    // 3-word frame to ch0, held until tick, then popped in order
    step(1, w(0, 30'h111), 0, 0, 0, '0);
    step(1, w(0, 30'h222), 0, 0, 0, '0);
    step(1, w(0, 30'h333), 1, 0, 0, '0);
    idle();
    check("t1_hold", ch_empty[0], 1);
    step(0, '0, 0, 1, 0, '0);
    check("t1_vis", ch_empty[0], 0);
    check("t1_w1", ch_dout[0 +: PW], 30'h111);
    step(0, '0, 0, 0, 0, 3'b001);
    check("t1_w2", ch_dout[0 +: PW], 30'h222);
    step(0, '0, 0, 0, 0, 3'b001);
    check("t1_w3", ch_dout[0 +: PW], 30'h333);
    step(0, '0, 0, 0, 0, 3'b001);
    check("t1_empty", ch_empty[0], 1);

    // overflow on ch1: 3 committed, then 2-word frame whose 2nd word overflows
    step(1, w(1, 30'hA1), 0, 0, 0, '0);
    step(1, w(1, 30'hA2), 0, 0, 0, '0);
    step(1, w(1, 30'hA3), 1, 0, 0, '0);
    step(1, w(1, 30'hB1), 0, 0, 0, '0);
    step(1, w(1, 30'hB2), 1, 0, 0, '0);
    check("t2_drop", frame_drop, 1);
    check("t2_ovf", overflow_error, 1);
    step(0, '0, 0, 1, 0, '0);
    check("t2_drop_clr", frame_drop, 0);
    check("t2_a1", ch_dout[PW +: PW], 30'hA1);
    step(0, '0, 0, 0, 0, 3'b010);
    check("t2_a2", ch_dout[PW +: PW], 30'hA2);
    step(0, '0, 0, 0, 0, 3'b010);
    check("t2_a3", ch_dout[PW +: PW], 30'hA3);
    step(0, '0, 0, 0, 0, 3'b010);
    check("t2_empty", ch_empty[1], 1);

    // invalid channel mid-frame: whole frame dropped, tready stays high
    step(1, w(0, 30'hC1), 0, 0, 0, '0);
    step(1, w(3, 30'hC2), 0, 0, 0, '0);
    check("t3_drop", frame_drop, 1);
    check("t3_tready1", tready, 1);
    step(1, w(0, 30'hC3), 1, 0, 0, '0);
    check("t3_tready2", tready, 1);
    check("t3_nodrop", frame_drop, 0);
    step(0, '0, 0, 1, 0, '0);
    check("t3_none", ch_empty, 3'b111);
    step(1, w(2, 30'hD1), 1, 1, 0, '0);
    check("t3_recv", ch_dout[2*PW +: PW], 30'hD1);
    step(0, '0, 0, 0, 0, 3'b100);

    // tlast with tick same cycle, then tick one cycle before tlast
    step(1, w(0, 30'hE1), 1, 1, 0, '0);
    check("t4_same", ch_empty[0], 0);
    step(0, '0, 0, 0, 0, 3'b001);
    step(1, w(0, 30'hF1), 0, 1, 0, '0);
    step(1, w(0, 30'hF2), 1, 0, 0, '0);
    check("t4_held", ch_empty[0], 1);
    step(0, '0, 0, 1, 0, '0);
    check("t4_f1", ch_dout[0 +: PW], 30'hF1);
    step(0, '0, 0, 0, 0, 3'b001);
    step(0, '0, 0, 0, 0, 3'b001);

    // read on empty, then flush with 5 stored words
    step(0, '0, 0, 0, 0, 3'b100);
    check("t5_rderr", read_error, 1);
    check("t5_empty", ch_empty, 3'b111);
    step(1, w(0, 30'h51), 0, 0, 0, '0);
    step(1, w(0, 30'h52), 1, 0, 0, '0);
    step(1, w(1, 30'h53), 0, 0, 0, '0);
    step(1, w(1, 30'h54), 0, 0, 0, '0);
    step(1, w(1, 30'h55), 1, 1, 0, '0);
    check("t5_stored", ch_empty, 3'b100);
    step(0, '0, 0, 0, 1, '0);
    check("t5_fl_tready", tready, 0);
    check("t5_fl_empty", ch_empty, 3'b111);
    check("t5_fl_rderr", read_error, 1);
    idle();
    check("t5_tready_back", tready, 1);

    // async reset mid-frame
    step(1, w(0, 30'h61), 0, 0, 0, '0);
    #3 aresetn = 1'b0;
    #1;
    check("t6_tready", tready, 0);
    check("t6_empty", ch_empty, 3'b111);
    check("t6_ovf", overflow_error, 0);
`ifdef RANC_INGRESS_STATS_EN
    check("t6_stat_acc", stat_accepted, 0);
    check("t6_stat_drp", stat_dropped, 0);
`endif
    #2 aresetn = 1'b1;
    @(posedge clk); #1;
    check("t6_tready_up", tready, 1);
    step(1, w(1, 30'h62), 1, 1, 0, '0);
    check("t6_new", ch_dout[PW +: PW], 30'h62);
    step(0, '0, 0, 0, 0, 3'b010);

    // randomized traffic, with one async reset in the middle
    for (int i = 0; i < 3000; i++) begin
      ch = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      for (int c = 0; c < NCH; c++) r[c] = ($urandom_range(0, 9) < 3);
      if (i == 1500) begin
        #2 aresetn = 1'b0;
        #3 aresetn = 1'b1;
      end
      step($urandom_range(0, 9) < 7, w(ch, PW'($urandom)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0, r);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
